// File: rtl/onchip_sram_port_arbiter.sv
// onchip_sram_port_arbiter
// Round-robin arbiter sharing the 64-bit (s2) port of the on-chip SRAM
// between two Avalon-MM masters. Supports single accesses and fixed-length
// incrementing bursts (1..MAX_BURST beats, addresses wrap modulo 2**ADDR_W).
//
// Ports:
//   clk, reset           : clock and synchronous active-high reset
//   mN_address/read/write/burstcount/writedata/byteenable : master N command
//   mN_waitrequest       : command/beat of master N not accepted this cycle
//   mN_readdata/readdatavalid : read return to master N (latency 1)
//   ram_address/chipselect/write/writedata/byteenable/clken : to SRAM s2
//   ram_readdata         : from SRAM s2 (read latency 1)
module onchip_sram_port_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 64,
  parameter int BE_W      = 8,
  parameter int BURST_W   = 4,
  parameter int MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  m0_address,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [BURST_W-1:0] m0_burstcount,
  input  logic [DATA_W-1:0]  m0_writedata,
  input  logic [BE_W-1:0]    m0_byteenable,
  output logic               m0_waitrequest,
  output logic [DATA_W-1:0]  m0_readdata,
  output logic               m0_readdatavalid,
  input  logic [ADDR_W-1:0]  m1_address,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [BURST_W-1:0] m1_burstcount,
  input  logic [DATA_W-1:0]  m1_writedata,
  input  logic [BE_W-1:0]    m1_byteenable,
  output logic               m1_waitrequest,
  output logic [DATA_W-1:0]  m1_readdata,
  output logic               m1_readdatavalid,
  output logic [ADDR_W-1:0]  ram_address,
  output logic               ram_chipselect,
  output logic               ram_write,
  output logic [DATA_W-1:0]  ram_writedata,
  output logic [BE_W-1:0]    ram_byteenable,
  output logic               ram_clken,
  input  logic [DATA_W-1:0]  ram_readdata
);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 owner_q, owner_d;
  logic [BURST_W-1:0]   beats_q, beats_d;   // beats still to issue after current
  logic [ADDR_W-1:0]    addr_q, addr_d;     // address of next burst beat
  logic                 rv_valid_q, rv_valid_d;
  logic                 rv_tag_q, rv_tag_d;

  // Per-master views indexed by master number.
  logic [1:0]           rd_req, wr_req, req, accept;
  logic [ADDR_W-1:0]    m_addr [2];
  logic [BURST_W-1:0]   m_bc   [2];
  logic [DATA_W-1:0]    m_wd   [2];
  logic [BE_W-1:0]      m_be   [2];

  logic                 gnt;
  logic [BURST_W-1:0]   gnt_beats;
  logic                 issue, issue_we, issue_tag;

  assign rd_req    = {m1_read, m0_read};
  assign wr_req    = {m1_write, m0_write};
  assign req       = rd_req | wr_req;
  assign m_addr[0] = m0_address;    assign m_addr[1] = m1_address;
  assign m_bc[0]   = m0_burstcount; assign m_bc[1]   = m1_burstcount;
  assign m_wd[0]   = m0_writedata;  assign m_wd[1]   = m1_writedata;
  assign m_be[0]   = m0_byteenable; assign m_be[1]   = m1_byteenable;

  function automatic logic [BURST_W-1:0] clamp_beats(input logic [BURST_W-1:0] bc);
    if (bc == '0)
      return BURST_W'(1);
    else if (bc > BURST_W'(MAX_BURST))
      return BURST_W'(MAX_BURST);
    else
      return bc;
  endfunction

  // On a tie the master not granted last wins; a lone requester always wins.
  assign gnt       = (&req) ? ~last_grant_q : req[1];
  assign gnt_beats = clamp_beats(m_bc[gnt]);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      beats_q      <= '0;
      addr_q       <= '0;
      rv_valid_q   <= 1'b0;
      rv_tag_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      beats_q      <= beats_d;
      addr_q       <= addr_d;
      rv_valid_q   <= rv_valid_d;
      rv_tag_q     <= rv_tag_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    beats_d      = beats_q;
    addr_d       = addr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          last_grant_d = gnt;
          owner_d      = gnt;
          addr_d       = m_addr[gnt] + ADDR_W'(1);
          beats_d      = gnt_beats - BURST_W'(1);
          if (gnt_beats > BURST_W'(1))
            state_d = wr_req[gnt] ? WR_BURST : RD_BURST;
        end
      end
      RD_BURST: begin
        addr_d  = addr_q + ADDR_W'(1);
        beats_d = beats_q - BURST_W'(1);
        if (beats_q == BURST_W'(1))
          state_d = IDLE;
      end
      WR_BURST: begin
        // A beat only advances when the owner actually presents write data.
        if (wr_req[owner_q]) begin
          addr_d  = addr_q + ADDR_W'(1);
          beats_d = beats_q - BURST_W'(1);
          if (beats_q == BURST_W'(1))
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. Nothing is issued while reset is high so a burst is cut
  // off in the very cycle reset is seen.
  always_comb begin
    issue          = 1'b0;
    issue_we       = 1'b0;
    issue_tag      = gnt;
    accept         = '0;
    ram_address    = addr_q;
    ram_writedata  = '0;
    ram_byteenable = '1;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            issue          = 1'b1;
            issue_we       = wr_req[gnt];   // read+write counts as write
            ram_address    = m_addr[gnt];
            ram_writedata  = m_wd[gnt];
            ram_byteenable = m_be[gnt];
            accept[gnt]    = 1'b1;
          end
        end
        RD_BURST: begin
          issue     = 1'b1;
          issue_tag = owner_q;
        end
        WR_BURST: begin
          issue_tag = owner_q;
          if (wr_req[owner_q]) begin
            issue           = 1'b1;
            issue_we        = 1'b1;
            ram_writedata   = m_wd[owner_q];
            ram_byteenable  = m_be[owner_q];
            accept[owner_q] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // One-stage return pipe matching the RAM read latency.
  assign rv_valid_d = issue & ~issue_we;
  assign rv_tag_d   = issue_tag;

  assign ram_chipselect   = issue;
  assign ram_write        = issue_we;
  assign ram_clken        = 1'b1;

  assign m0_waitrequest   = req[0] & ~accept[0] & ~reset;
  assign m1_waitrequest   = req[1] & ~accept[1] & ~reset;
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign m0_readdatavalid = rv_valid_q & ~rv_tag_q & ~reset;
  assign m1_readdatavalid = rv_valid_q &  rv_tag_q & ~reset;

endmodule
